uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ byte sources share one UART transmitter.
// Under PKT_LOCK the owner keeps the grant until it has sent a byte flagged last.
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PKT_LOCK = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_write,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SEND,
        SETTLE,
        WAIT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_owner;
    logic               last_q;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_found;
    logic [NUM_REQ-1:0] rr_oh;
    logic [NUM_REQ-1:0] owner_oh;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int step);
        int sum;
        sum = (int'(base) + step) % NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Search starts just after the previous owner, so it has lowest priority.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rr_found = 1'b0;
        rr_idx   = last_owner;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!rr_found && req_valid[wrap_add(last_owner, k)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_add(last_owner, k);
            end
        end
    end

    assign rr_oh    = NUM_REQ'(1) << rr_idx;
    assign owner_oh = NUM_REQ'(1) << owner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            req_ready  <= '0;
            tx_write   <= 1'b0;
            tx_data    <= 8'h00;
            last_q     <= 1'b0;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
        end else begin
            // NOTE: pulses default low every cycle, so any assertion below lasts exactly one cycle.
            tx_write  <= 1'b0;
            req_ready <= '0;
            unique case (state)
                IDLE: begin
                    grant <= '0;
                    if (|req_valid) state <= ARB;
                end
                ARB: begin
                    if (rr_found) begin
                        owner <= rr_idx;
                        grant <= rr_oh;
                        state <= SEND;
                    end else begin
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (!tx_busy && req_valid[owner]) begin
                        tx_write  <= 1'b1;
                        req_ready <= owner_oh;
                        tx_data   <= req_data[{owner, 3'b000} +: 8];
                        last_q    <= req_last[owner];
                        state     <= SETTLE;
                    end
                end
                // The transmitter raises busy one cycle after the write; skip that cycle.
                SETTLE: state <= WAIT;
                WAIT: begin
                    if (!tx_busy) begin
                        if ((PKT_LOCK != 0) && !last_q) begin
                            state <= SEND;
                        end else begin
                            last_owner <= owner;
                            grant      <= '0;
                            state      <= ARB;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
